mio_bus_ctrl: RTL and testbench

//  Memory/IO bus controller directly downstream of the single-cycle CPU core.

---
 rtl/mio_bus_ctrl.sv | 86 ++++++++
 tb/tb_mio_bus_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: decodes core bus requests to RAM, LED/switch GPIO and an optional timer, with MIO_ready handshake.
// Define MIO_TIMER_EN to map a free-running 32-bit timer at 0xF000_0004; otherwise that address is unmapped.
module mio_bus_ctrl #(
   parameter int RAM_AW   = 10,
   parameter int RAM_WAIT = 1,
   parameter int GPIO_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CPU_MIO,
   input  logic              MemRW,
   input  logic [31:0]       Addr_in,
   input  logic [31:0]       Data_wr,
   output logic [31:0]       Data_rd,
   output logic              MIO_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_we,
   input  logic [31:0]       ram_rdata,
   input  logic [GPIO_W-1:0] sw,
   output logic [GPIO_W-1:0] led,
   output logic              bus_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
   state_t            r_state, w_next;
   logic [2:0]        r_wcnt;
   logic [31:0]       r_data_rd;
   logic              r_ram_we;
   logic [GPIO_W-1:0] r_led;
   logic              r_bus_err;
   logic              w_ram, w_gpio, w_tmr, w_unm, w_ram_rd, w_start, w_fast, w_wait_done;
   logic [31:0]       w_tmr_val;
   logic              w_unused;
   assign w_ram       = Addr_in[31:28] == 4'h0;
   assign w_gpio      = Addr_in[31:2] == 30'h3C00_0000;
   assign w_unm       = !(w_ram || w_gpio || w_tmr);
   assign w_ram_rd    = w_ram && !MemRW;
   assign w_start     = r_state == IDLE && CPU_MIO;
   // every access except a RAM read completes straight from IDLE and commits its side effect here
   assign w_fast      = w_start && !w_ram_rd;
   assign w_wait_done = r_state == WAIT && CPU_MIO && r_wcnt == 3'd0;
   assign w_unused    = ^Addr_in[1:0];
`ifdef MIO_TIMER_EN
   logic [31:0] r_timer;
   assign w_tmr     = Addr_in[31:2] == 30'h3C00_0001;
   assign w_tmr_val = r_timer;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_timer <= 32'h0;
      else      r_timer <= (w_fast && w_tmr && MemRW) ? Data_wr : r_timer + 32'd1;
   end
`else
   assign w_tmr     = 1'b0;
   assign w_tmr_val = 32'h0;
`endif
   always_comb begin
      w_next = IDLE;
      if (r_state == IDLE)      w_next = CPU_MIO ? (w_ram_rd ? WAIT : ACK) : IDLE;
      else if (r_state == WAIT) w_next = !CPU_MIO ? IDLE : (r_wcnt == 3'd0 ? ACK : WAIT);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_wcnt    <= 3'd0;
         r_data_rd <= 32'h0;
         r_ram_we  <= 1'b0;
         r_led     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_wcnt   <= (w_start && w_ram_rd) ? 3'(RAM_WAIT) :
                     (r_state == WAIT && CPU_MIO && r_wcnt != 3'd0) ? r_wcnt - 3'd1 : r_wcnt;
         r_ram_we <= w_fast && w_ram && MemRW;
         if (w_fast && w_gpio && MemRW) r_led <= Data_wr[GPIO_W-1:0];
         if (w_fast && w_unm) r_bus_err <= 1'b1;
         if (w_fast && !MemRW) r_data_rd <= w_gpio ? 32'(sw) : w_tmr ? w_tmr_val : 32'h0;
         else if (w_wait_done) r_data_rd <= ram_rdata;
      end
   end
   assign MIO_ready = r_state == ACK;
   assign Data_rd   = r_data_rd;
   assign ram_we    = r_ram_we;
   assign led       = r_led;
   assign bus_err   = r_bus_err;
   assign ram_addr  = Addr_in[RAM_AW+1:2];
   assign ram_wdata = Data_wr;
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: directed and randomized checks of mio_bus_ctrl against a transaction-level reference model.
module tb_mio_bus_ctrl;
   localparam int AW = 10, RW = 1, GW = 16;
   logic          clk = 1'b0, rst = 1'b1;
   logic          CPU_MIO = 1'b0, MemRW = 1'b0;
   logic [31:0]   Addr_in = 32'h0, Data_wr = 32'h0, Data_rd, ram_wdata, ram_rdata;
   logic          MIO_ready, ram_we, bus_err;
   logic [AW-1:0] ram_addr;
   logic [GW-1:0] sw = '0, led;
   int            checks = 0, errors = 0;
   int unsigned   ecount = 0;
   logic [31:0]   ram [0:(1<<AW)-1];
   logic [31:0]   m_mem [int unsigned];
   logic [31:0]   m_rd = 32'h0, t_base = 32'h0;
   logic [GW-1:0] m_led = '0;
   logic          m_err = 1'b0;
   int unsigned   e_base = 1;
   mio_bus_ctrl #(.RAM_AW(AW), .RAM_WAIT(RW), .GPIO_W(GW)) dut (
      .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .MemRW(MemRW), .Addr_in(Addr_in),
      .Data_wr(Data_wr), .Data_rd(Data_rd), .MIO_ready(MIO_ready), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .sw(sw), .led(led),
      .bus_err(bus_err));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end
   always @(posedge clk) if (rst) ecount <= ecount + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h exp %h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      m_rd = 32'h0; m_led = '0; m_err = 1'b0; t_base = 32'h0; e_base = ecount + 1;
   endtask
   task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d, output int lat);
      int unsigned e, idx;
      int  we_cnt, exp_lat;
      logic is_ram, is_gpio, is_tmr, got;
      idx     = (a >> 2) % (1 << AW);
      is_ram  = a[31:28] == 4'h0;
      is_gpio = (a >> 2) == 32'h3C00_0000;
`ifdef MIO_TIMER_EN
      is_tmr  = (a >> 2) == 32'h3C00_0001;
`else
      is_tmr  = 1'b0;
`endif
      exp_lat = (is_ram && !rw) ? 2 + RW : 1;
      CPU_MIO = 1'b1; MemRW = rw; Addr_in = a; Data_wr = d;
      lat = 0; we_cnt = 0; got = 1'b0; e = 0;
      while (!got && lat < 20) begin
         @(posedge clk); @(negedge clk);
         lat++;
         if (lat == 1) e = ecount;
         if (ram_we) begin
            we_cnt++;
            chk("ram_addr@we", 32'(ram_addr), idx);
            chk("ram_wdata@we", ram_wdata, d);
         end
         got = MIO_ready;
      end
      chk("ack_seen", 32'(got), 32'd1);
      if (rw) begin
         if (is_ram) m_mem[idx] = d;
         else if (is_gpio) m_led = d[GW-1:0];
         else if (is_tmr) begin t_base = d; e_base = e + 1; end
         else m_err = 1'b1;
      end else begin
         if (is_ram) m_rd = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
         else if (is_gpio) m_rd = 32'(sw);
         else if (is_tmr) m_rd = t_base + (e - e_base);
         else begin m_rd = 32'h0; m_err = 1'b1; end
      end
      chk("latency", lat, exp_lat);
      chk("ram_we_cnt", we_cnt, (is_ram && rw) ? 1 : 0);
      chk("Data_rd", Data_rd, m_rd);
      chk("led", 32'(led), 32'(m_led));
      chk("bus_err", 32'(bus_err), 32'(m_err));
      CPU_MIO = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("ready_pulse", 32'(MIO_ready), 32'd0);
      chk("we_pulse", 32'(ram_we), 32'd0);
   endtask
   initial begin
      int lat, k;
      logic [31:0] a, d;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
      #2 rst = 1'b0;
      #1;
      chk("rst_Data_rd", Data_rd, 32'h0);
      chk("rst_ready", 32'(MIO_ready), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
      req(1'b1, 32'h0000_0010, 32'hCAFE_F00D, lat);
      chk("ram_wr_lat", lat, 1);
      req(1'b0, 32'h0000_0010, 32'h0, lat);
      chk("ram_rd_lat", lat, 3);
      chk("ram_rd_data", Data_rd, 32'hCAFE_F00D);
      req(1'b1, 32'hF000_0000, 32'h0001_A5A5, lat);
      chk("gpio_led", 32'(led), 32'h0000_A5A5);
      sw = 16'h1234;
      req(1'b0, 32'hF000_0000, 32'h0, lat);
      chk("gpio_rd", Data_rd, 32'h0000_1234);
      req(1'b0, 32'h8000_0000, 32'h0, lat);
      chk("unm_lat", lat, 1);
      chk("unm_data", Data_rd, 32'h0);
      chk("unm_err", 32'(bus_err), 32'd1);
      req(1'b1, 32'h0000_0040, 32'h1111_2222, lat);
      chk("err_sticky", 32'(bus_err), 32'd1);
      CPU_MIO = 1'b1; MemRW = 1'b0; Addr_in = 32'h0000_0040;
      @(posedge clk); @(negedge clk);
      CPU_MIO = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk("abort_no_ack", 32'(MIO_ready), 32'd0);
      end
      chk("abort_Data_rd", Data_rd, m_rd);
      req(1'b0, 32'h0000_0040, 32'h0, lat);
      chk("after_abort", Data_rd, 32'h1111_2222);
      req(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, lat);
      @(negedge clk);
      req(1'b0, 32'hF000_0004, 32'h0, lat);
      chk("timer_wrap_rd", Data_rd, 32'h0);
`ifdef MIO_TIMER_EN
      chk("timer_no_err", 32'(bus_err), 32'd1);
`else
      chk("timer_unm_err", 32'(bus_err), 32'd1);
`endif
      CPU_MIO = 1'b1; MemRW = 1'b0; Addr_in = 32'h0000_0080;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstw_ready", 32'(MIO_ready), 32'd0);
      chk("rstw_led", 32'(led), 32'd0);
      chk("rstw_err", 32'(bus_err), 32'd0);
      chk("rstw_Data_rd", Data_rd, 32'h0);
      CPU_MIO = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rstw_no_ack", 32'(MIO_ready), 32'd0);
      end
      for (int n = 0; n < 200; n++) begin
         k  = $urandom_range(0, 5);
         d  = $urandom;
         sw = GW'($urandom);
         a  = $urandom;
         if (k <= 1 || k == 5) begin
            a[31:28] = 4'h0;
            a[11:2]  = 10'($urandom_range(0, 15));
         end else if (k == 2) a = 32'hF000_0000 | 32'($urandom_range(0, 3));
         else if (k == 3) a = 32'hF000_0004 | 32'($urandom_range(0, 3));
         else if (a[31:28] == 4'h0 || a[31:3] == 29'h1E00_0000) a[31:28] = 4'h8;
         req(k == 5 ? 1'b0 : 1'($urandom_range(0, 1)), a, d, lat);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
